// File: rtl/seed_packer_if.sv
// Byte-RAM read / word-RAM write bus of the seed packer, plus its start/busy/done control.
// slave is the packer side; master is the environment (control logic and both RAMs).
interface seed_packer_if #(
    parameter int BA_W = 5,
    parameter int WA_W = 3
);
    logic            start;
    logic            busy;
    logic            done;
    logic [BA_W-1:0] IR_addr;
    logic [7:0]      IR_do;
    logic [WA_W-1:0] OR_addr;
    logic [31:0]     OR_di;
    logic            OR_we;

    modport slave (
        input  start, IR_do,
        output busy, done, IR_addr, OR_addr, OR_di, OR_we
    );

    modport master (
        output start, IR_do,
        input  busy, done, IR_addr, OR_addr, OR_di, OR_we
    );
endinterface

// File: rtl/seed_packer.sv
// Reads 4*WORDS bytes from a synchronous-read byte RAM and writes them as
// little-endian 32-bit words into a word RAM, one byte per cycle.
module seed_packer #(
    parameter int WORDS = 8,
    parameter int BA_W  = $clog2(4*WORDS),
    parameter int WA_W  = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         rst_n,
    seed_packer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [BA_W-1:0] LAST_BYTE = BA_W'(4*WORDS-1);

    state_t          r_state;
    state_t          w_next;
    logic [BA_W-1:0] r_ir_addr;
    logic [BA_W-1:0] r_cnt;
    logic            r_valid;
    logic [23:0]     r_asm;
    logic [WA_W-1:0] r_or_addr;
    logic [31:0]     r_or_di;
    logic            r_or_we;

    logic w_accept;
    logic w_fetch_last;
    logic w_lane3;

    assign w_accept     = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    assign w_fetch_last = (r_state == S_FETCH) && (r_ir_addr == LAST_BYTE);
    assign w_lane3      = r_valid && (r_cnt[1:0] == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DRAIN ends on the cycle carrying the final word write; no earlier write lands in DRAIN.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = w_accept ? S_FETCH : S_IDLE;
            S_FETCH: w_next = w_fetch_last ? S_DRAIN : S_FETCH;
            S_DRAIN: w_next = r_or_we ? S_DONE : S_DRAIN;
            S_DONE:  w_next = w_accept ? S_FETCH : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir_addr <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_asm     <= '0;
            r_or_addr <= '0;
            r_or_di   <= '0;
            r_or_we   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ir_addr <= '0;
            end else if (r_state == S_FETCH) begin
                r_ir_addr <= w_fetch_last ? '0 : r_ir_addr + BA_W'(1);
            end

            r_valid <= (r_state == S_FETCH);

            // accept and capture never coincide: the valid flag is clear in IDLE/DONE
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_valid) begin
                r_cnt <= r_cnt + BA_W'(1);
                unique case (r_cnt[1:0])
                    2'd0:    r_asm[7:0]   <= bus.IR_do;
                    2'd1:    r_asm[15:8]  <= bus.IR_do;
                    2'd2:    r_asm[23:16] <= bus.IR_do;
                    default: r_asm        <= r_asm;
                endcase
            end

            r_or_we <= w_lane3;
            r_or_di <= w_lane3 ? {bus.IR_do, r_asm} : '0;
            if (w_lane3) begin
                r_or_addr <= r_cnt[BA_W-1:2];
            end
        end
    end

    assign bus.busy    = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign bus.done    = (r_state == S_DONE);
    assign bus.IR_addr = r_ir_addr;
    assign bus.OR_addr = r_or_addr;
    assign bus.OR_di   = r_or_di;
    assign bus.OR_we   = r_or_we;
endmodule

// File: tb/tb_seed_packer.sv
// Bench for seed_packer: WORDS=8 and WORDS=4 instances with behavioural byte/word RAMs,
// each run checked cycle by cycle against timing and data derived from the packing rules.
module tb_seed_packer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seed_packer_if #(.BA_W(5), .WA_W(3)) b8 ();
    seed_packer_if #(.BA_W(4), .WA_W(2)) b4 ();

    seed_packer #(.WORDS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    seed_packer #(.WORDS(4), .BA_W(4), .WA_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    logic [7:0]  bm8 [32];
    logic [7:0]  bm4 [16];
    logic [31:0] wm8 [8];
    logic [31:0] wm4 [4];
    logic [7:0]  exp_b [32];

    always @(posedge clk) begin
        b8.IR_do <= bm8[b8.IR_addr];
        b4.IR_do <= bm4[b4.IR_addr];
        if (b8.OR_we) wm8[b8.OR_addr] <= b8.OR_di;
        if (b4.OR_we) wm4[b4.OR_addr] <= b4.OR_di;
    end

    bit          sel;
    logic        s_busy, s_done, s_we;
    logic [31:0] s_iraddr, s_oraddr, s_di;

    always_comb begin
        if (sel) begin
            s_busy = b4.busy; s_done = b4.done; s_we = b4.OR_we;
            s_iraddr = 32'(b4.IR_addr); s_oraddr = 32'(b4.OR_addr); s_di = b4.OR_di;
        end else begin
            s_busy = b8.busy; s_done = b8.done; s_we = b8.OR_we;
            s_iraddr = 32'(b8.IR_addr); s_oraddr = 32'(b8.OR_addr); s_di = b8.OR_di;
        end
    end

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int unsigned w);
        return {exp_b[4*w+3], exp_b[4*w+2], exp_b[4*w+1], exp_b[4*w]};
    endfunction

    // mode 0: incrementing, 1: random, 2: 0xA0 + i
    task automatic fill(input int unsigned nbytes, input int unsigned mode);
        for (int unsigned i = 0; i < nbytes; i++) begin
            case (mode)
                0:       exp_b[i] = 8'(i);
                1:       exp_b[i] = 8'($urandom_range(0, 255));
                default: exp_b[i] = 8'(8'hA0 + i);
            endcase
            if (sel) bm4[i[3:0]] = exp_b[i];
            else     bm8[i[4:0]] = exp_b[i];
        end
    endtask

    task automatic set_start(input bit v);
        if (sel) b4.start = v;
        else     b8.start = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(s_busy), 32'd0);
        check({tag, "_done"}, 32'(s_done), 32'd0);
        check({tag, "_we"}, 32'(s_we), 32'd0);
        check({tag, "_iraddr"}, s_iraddr, 32'd0);
        check({tag, "_oraddr"}, s_oraddr, 32'd0);
        check({tag, "_di"}, s_di, 32'd0);
    endtask

    // One run of W words; cycle k counts from the cycle after the edge sampling start.
    task automatic run(input int unsigned W, input bit hold, input bit inject,
                       input int unsigned abort_k);
        bit exp_we;
        for (int unsigned w = 0; w < 8; w++) wm8[w] = 32'hDEADBEEF;
        for (int unsigned w = 0; w < 4; w++) wm4[w] = 32'hDEADBEEF;
        set_start(1'b1);
        for (int unsigned k = 1; k <= 4*W + 3; k++) begin
            @(posedge clk);
            #1;
            set_start(hold || (inject && (k == 3 || k == 17 || k == 34)));
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("rst_mid");
                for (int unsigned j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("rst_hold_we", 32'(s_we), 32'd0);
                    check("rst_hold_busy", 32'(s_busy), 32'd0);
                end
                return;
            end
            @(negedge clk);
            exp_we = (k >= 6) && (k <= 4*W + 2) && ((k - 6) % 4 == 0);
            check("busy", 32'(s_busy), 32'(k <= 4*W + 2));
            check("done", 32'(s_done), 32'(k == 4*W + 3));
            check("we", 32'(s_we), 32'(exp_we));
            check("iraddr", s_iraddr, (k <= 4*W) ? 32'(k - 1) : 32'd0);
            if (exp_we) begin
                check("oraddr", s_oraddr, 32'((k - 6) / 4));
                check("di", s_di, exp_word((k - 6) / 4));
            end else begin
                check("di_idle", s_di, 32'd0);
            end
        end
        for (int unsigned w = 0; w < W; w++)
            check("wram", sel ? wm4[w[1:0]] : wm8[w[2:0]], exp_word(w));
    endtask

    initial begin
        rst_n = 1'b0;
        b8.start = 1'b0;
        b4.start = 1'b0;
        sel = 1'b0;
        #1 check_all_zero("reset8");
        sel = 1'b1;
        #1 check_all_zero("reset4");
        sel = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fill(32, 0);
        run(8, 1'b0, 1'b0, 0);
        check("inc_w0", wm8[0], 32'h03020100);
        check("inc_w7", wm8[7], 32'h1F1E1D1C);
        repeat (2) @(negedge clk);

        for (int unsigned r = 0; r < 100; r++) begin
            fill(32, 1);
            run(8, 1'b0, 1'b0, 0);
            if (r % 3 == 0) @(negedge clk);
        end

        fill(32, 1);
        run(8, 1'b1, 1'b0, 0);
        run(8, 1'b0, 1'b0, 0);
        @(negedge clk);

        fill(32, 1);
        run(8, 1'b0, 1'b1, 0);
        @(negedge clk);

        fill(32, 1);
        run(8, 1'b0, 1'b0, 20);
        @(negedge clk);
        rst_n = 1'b1;
        fill(32, 1);
        run(8, 1'b0, 1'b0, 0);
        @(negedge clk);

        sel = 1'b1;
        #1;
        fill(16, 2);
        run(4, 1'b0, 1'b0, 0);
        check("v4_w0", wm4[0], 32'hA3A2A1A0);
        check("v4_w3", wm4[3], 32'hAFAEADAC);
        fill(16, 1);
        run(4, 1'b0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
